univ_shift_register: RTL and testbench
======================================

// Module: univ_shift_register
//
// PURPOSE
//   Parametrised universal shift register: hold, shift right, shift left and parallel load.
//   Replaces the fixed 4-bit right-only SIPO in lab designs and adds a shift counter that
//   flags a complete serial word. Sits between a serial line and a parallel datapath;
//   works as SIPO, PISO or bidirectional shifter depending on mode.
//
// PARAMETERS
//   WIDTH   4   register width in bits; legal range 2..32
//   CNT_W   $clog2(WIDTH) (localparam)   shift-counter width
//
// PORTS
//   clk         in   1      clock; all state updates on posedge
//   clrb        in   1      asynchronous, active-low reset
//   mode        in   2      00 hold, 01 shift right, 10 shift left, 11 parallel load
//   SDR         in   1      serial in for right shift; enters Q[WIDTH-1]
//   SDL         in   1      serial in for left shift; enters Q[0]
//   D           in   WIDTH  parallel load data
//   Q           out  WIDTH  register contents
//   sout_r      out  1      serial out for right shift; equals Q[0] (combinational)
//   sout_l      out  1      serial out for left shift; equals Q[WIDTH-1] (combinational)
//   word_valid  out  1      one-cycle pulse: WIDTH consecutive same-direction shifts completed
//
// BEHAVIOUR
//   - Reset (clrb=0): takes effect immediately, independent of clk.
//     Q=0, cnt=0, last_dir=0 (right), word_valid=0. Held while clrb=0; mode is ignored.
//   - Mode effects on posedge clk with clrb=1:
//     - 00: Q, cnt and last_dir unchanged; word_valid<=0.
//     - 01: Q<={SDR, Q[WIDTH-1:1]}.
//     - 10: Q<={Q[WIDTH-2:0], SDL}.
//     - 11: Q<=D; cnt<=0; word_valid<=0; last_dir unchanged.
//   - Shift counter (modes 01/10):
//     - Direction differs from last_dir: cnt<=1, last_dir<=new direction, word_valid<=0.
//       Exception: WIDTH=2 with cnt wrap gives no exception; the counter simply restarts at 1.
//     - Same direction, cnt==WIDTH-1: cnt<=0, word_valid<=1.
//     - Same direction, otherwise: cnt<=cnt+1, word_valid<=0.
//     - After reset or load, the first shift in either direction counts as 1 (cnt=0).
//       The direction-change rule still updates last_dir.
//   - word_valid timing: registered. High during the cycle after the WIDTH-th shift edge,
//     i.e. while Q holds the completed word. Low on the next edge unless another word
//     completes. Back-to-back words pulse every WIDTH shifts.
//   - Hold cycles between shifts do not break a word; the count resumes.
//   - Latency: Q reflects mode/data one edge after sampling. Serial outs follow Q
//     combinationally.
//   - Reset asserted mid-word discards the partial count. No word_valid is produced
//     for the aborted word.
//
// STRUCTURE
//   - Shared package: mode encodings MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10,
//     MODE_LOAD=2'b11, and DIR_R=1'b0, DIR_L=1'b1.
//   - Sub-module shift_word_counter (clk, clrb, shift, dir, clear -> word_valid): holds cnt,
//     last_dir and the word_valid register.
//   - Top level: data register, mode decode, serial outputs.
//
// TESTING  (WIDTH=4 unless stated)
//   1. Reset: clrb=0, mode=01, SDR=1, clk running
//      -> Q=0000, word_valid=0 throughout.
//      Release clrb -> first edge gives Q=1000.
//   2. SIPO: from 0000, mode=01, SDR=1 for 4 edges
//      -> Q=1000,1100,1110,1111.
//      word_valid=1 for exactly the one cycle after the 4th edge.
//   3. PISO: mode=11, D=1010 -> Q=1010, cnt=0.
//      Then mode=10, SDL=0 -> sout_l=1 before the edge, Q=0100 after it.
//      3 more shifts -> word_valid pulse after the 4th.
//   4. Direction change: 2 right shifts, then mode=10
//      -> cnt restarts at 1; word_valid only after 4 consecutive left shifts (6th shift total).
//   5. Hold mid-word: 2 right shifts, 3 cycles mode=00 (Q/cnt frozen, word_valid=0),
//      2 right shifts -> word_valid after the 4th shift.
//   6. Async reset mid-word: after 3 shifts, pulse clrb low between edges
//      -> Q=0 immediately, no word_valid.
//      Then 4 shifts -> single pulse.
//      Repeat 2 with WIDTH=8: pulse after the 8th shift only.

Source files
------------

// File: rtl/univ_shift_register_pkg.sv
// Shared encodings for the universal shift register: operating modes and shift directions.
package univ_shift_register_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  function automatic logic mode_is_shift(mode_t m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/univ_shift_register_if.sv
// Control, data and status bundle of the universal shift register.
interface univ_shift_register_if
  import univ_shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) ();

  mode_t            mode;
  logic             SDR;
  logic             SDL;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             sout_r;
  logic             sout_l;
  logic             word_valid;

  modport master (
    output mode, SDR, SDL, D,
    input  Q, sout_r, sout_l, word_valid
  );

  modport slave (
    input  mode, SDR, SDL, D,
    output Q, sout_r, sout_l, word_valid
  );

endinterface

// File: rtl/shift_word_counter.sv
// Counts consecutive same-direction shifts and pulses word_valid when WIDTH of them complete.
module shift_word_counter
  import univ_shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic clk,
  input  logic clrb,
  input  logic shift,
  input  logic dir,
  input  logic clear,
  output logic word_valid
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;

  always_comb begin
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    valid_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (shift) begin
      // A direction change starts a new word with this shift as its first bit.
      if (dir != dir_q) begin
        cnt_d = CNT_W'(1);
        dir_d = dir;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      cnt_q   <= '0;
      dir_q   <= DIR_R;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
    end
  end

  assign word_valid = valid_q;

endmodule

// File: rtl/univ_shift_register.sv
// Universal shift register: hold, shift right/left and parallel load, with word-complete flag.
module univ_shift_register
  import univ_shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                clrb,
  univ_shift_register_if.slave bus
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             shift;
  logic             dir;
  logic             clear;
  logic             word_valid;

  always_comb begin
    data_d = data_q;
    dir    = DIR_R;
    clear  = 1'b0;
    unique case (bus.mode)
      MODE_HOLD: data_d = data_q;
      MODE_SHR: begin
        data_d = {bus.SDR, data_q[WIDTH-1:1]};
        dir    = DIR_R;
      end
      MODE_SHL: begin
        data_d = {data_q[WIDTH-2:0], bus.SDL};
        dir    = DIR_L;
      end
      MODE_LOAD: begin
        data_d = bus.D;
        clear  = 1'b1;
      end
      default: data_d = data_q;
    endcase
    shift = mode_is_shift(bus.mode);
  end

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  shift_word_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk        (clk),
    .clrb       (clrb),
    .shift      (shift),
    .dir        (dir),
    .clear      (clear),
    .word_valid (word_valid)
  );

  assign bus.Q          = data_q;
  assign bus.sout_r     = data_q[0];
  assign bus.sout_l     = data_q[WIDTH-1];
  assign bus.word_valid = word_valid;

endmodule

// File: tb/tb_univ_shift_register.sv
// Directed bench for univ_shift_register at WIDTH=4 and WIDTH=8.
module tb_univ_shift_register;
  import univ_shift_register_pkg::*;

  logic clk  = 1'b0;
  logic clrb = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  univ_shift_register_if #(.WIDTH(4)) bus4 ();
  univ_shift_register_if #(.WIDTH(8)) bus8 ();

  univ_shift_register #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .clrb (clrb),
    .bus  (bus4.slave)
  );

  univ_shift_register #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .clrb (clrb),
    .bus  (bus8.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge; the low pulse ends well before the next edge.
  task automatic pulse_reset();
    clrb = 1'b0;
    #2;
    clrb = 1'b1;
  endtask

  task automatic test_reset();
    bus4.mode = MODE_SHR;
    bus4.SDR  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus4.Q !== 4'b0000 || bus4.word_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold[%0d] got Q=%b wv=%b exp Q=0000 wv=0", i, bus4.Q,
                 bus4.word_valid);
      end
    end
    #2;
    clrb = 1'b1;
    tick();
    checks++;
    if (bus4.Q !== 4'b1000 || bus4.word_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got Q=%b wv=%b exp Q=1000 wv=0", bus4.Q, bus4.word_valid);
    end
  endtask

  task automatic test_sipo();
    logic [3:0] exp_q [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    logic       exp_v [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    pulse_reset();
    checks++;
    if (bus4.Q !== 4'b0000) begin
      failures++;
      $display("FAIL sipo_start got Q=%b exp 0000", bus4.Q);
    end
    bus4.mode = MODE_SHR;
    bus4.SDR  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus4.Q !== exp_q[i] || bus4.word_valid !== exp_v[i]) begin
        failures++;
        $display("FAIL sipo[%0d] got Q=%b wv=%b exp Q=%b wv=%b", i, bus4.Q, bus4.word_valid,
                 exp_q[i], exp_v[i]);
      end
    end
    bus4.mode = MODE_HOLD;
    tick();
    checks++;
    if (bus4.Q !== 4'b1111 || bus4.word_valid !== 1'b0) begin
      failures++;
      $display("FAIL sipo_after got Q=%b wv=%b exp Q=1111 wv=0", bus4.Q, bus4.word_valid);
    end
  endtask

  task automatic test_piso();
    logic [3:0] exp_q [3] = '{4'b1001, 4'b0011, 4'b0111};
    logic       exp_v [3] = '{1'b0, 1'b0, 1'b1};
    bus4.mode = MODE_LOAD;
    bus4.D    = 4'b1010;
    tick();
    checks++;
    if (bus4.Q !== 4'b1010 || bus4.word_valid !== 1'b0) begin
      failures++;
      $display("FAIL piso_load got Q=%b wv=%b exp Q=1010 wv=0", bus4.Q, bus4.word_valid);
    end
    bus4.mode = MODE_SHL;
    bus4.SDL  = 1'b0;
    #1;
    checks++;
    if (bus4.sout_l !== 1'b1 || bus4.sout_r !== 1'b0) begin
      failures++;
      $display("FAIL piso_sout got sout_l=%b sout_r=%b exp 1 0", bus4.sout_l, bus4.sout_r);
    end
    tick();
    checks++;
    if (bus4.Q !== 4'b0100 || bus4.word_valid !== 1'b0) begin
      failures++;
      $display("FAIL piso_shift0 got Q=%b wv=%b exp Q=0100 wv=0", bus4.Q, bus4.word_valid);
    end
    bus4.SDL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus4.Q !== exp_q[i] || bus4.word_valid !== exp_v[i]) begin
        failures++;
        $display("FAIL piso[%0d] got Q=%b wv=%b exp Q=%b wv=%b", i + 1, bus4.Q,
                 bus4.word_valid, exp_q[i], exp_v[i]);
      end
    end
    checks++;
    if (bus4.sout_l !== 1'b0 || bus4.sout_r !== 1'b1) begin
      failures++;
      $display("FAIL piso_sout_end got sout_l=%b sout_r=%b exp 0 1", bus4.sout_l, bus4.sout_r);
    end
    bus4.mode = MODE_HOLD;
    tick();
  endtask

  task automatic test_dir_change();
    logic [3:0] exp_q [6] = '{4'b1000, 4'b1100, 4'b1001, 4'b0011, 4'b0111, 4'b1111};
    logic       exp_v [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pulse_reset();
    bus4.SDR = 1'b1;
    bus4.SDL = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus4.mode = (i < 2) ? MODE_SHR : MODE_SHL;
      tick();
      checks++;
      if (bus4.Q !== exp_q[i] || bus4.word_valid !== exp_v[i]) begin
        failures++;
        $display("FAIL dir_change[%0d] got Q=%b wv=%b exp Q=%b wv=%b", i, bus4.Q,
                 bus4.word_valid, exp_q[i], exp_v[i]);
      end
    end
    bus4.mode = MODE_HOLD;
    tick();
  endtask

  task automatic test_hold();
    mode_t      seq   [7] = '{MODE_SHR, MODE_SHR, MODE_HOLD, MODE_HOLD, MODE_HOLD,
                              MODE_SHR, MODE_SHR};
    logic       sdr   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp_q [7] = '{4'b1000, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0110, 4'b0011};
    logic       exp_v [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      bus4.mode = seq[i];
      bus4.SDR  = sdr[i];
      tick();
      checks++;
      if (bus4.Q !== exp_q[i] || bus4.word_valid !== exp_v[i]) begin
        failures++;
        $display("FAIL hold[%0d] got Q=%b wv=%b exp Q=%b wv=%b", i, bus4.Q, bus4.word_valid,
                 exp_q[i], exp_v[i]);
      end
    end
    bus4.mode = MODE_HOLD;
    tick();
    checks++;
    if (bus4.word_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_pulse_end got wv=%b exp 0", bus4.word_valid);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_q [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    logic       exp_v [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    pulse_reset();
    bus4.mode = MODE_SHR;
    bus4.SDR  = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    #2;
    clrb = 1'b0;
    #1;
    checks++;
    if (bus4.Q !== 4'b0000 || bus4.word_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got Q=%b wv=%b exp Q=0000 wv=0", bus4.Q, bus4.word_valid);
    end
    #1;
    clrb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus4.Q !== exp_q[i] || bus4.word_valid !== exp_v[i]) begin
        failures++;
        $display("FAIL async_after[%0d] got Q=%b wv=%b exp Q=%b wv=%b", i, bus4.Q,
                 bus4.word_valid, exp_q[i], exp_v[i]);
      end
    end
  endtask

  // Continues straight on from test_async_reset with no gap between words.
  task automatic test_back_to_back();
    logic [3:0] exp_q [4] = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};
    logic       exp_v [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    bus4.mode = MODE_SHR;
    bus4.SDR  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus4.Q !== exp_q[i] || bus4.word_valid !== exp_v[i]) begin
        failures++;
        $display("FAIL back_to_back[%0d] got Q=%b wv=%b exp Q=%b wv=%b", i, bus4.Q,
                 bus4.word_valid, exp_q[i], exp_v[i]);
      end
    end
    bus4.mode = MODE_HOLD;
    tick();
  endtask

  task automatic test_width8();
    logic [7:0] exp_q [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    pulse_reset();
    bus8.mode = MODE_SHR;
    bus8.SDR  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus8.Q !== exp_q[i] || bus8.word_valid !== (i == 7)) begin
        failures++;
        $display("FAIL width8[%0d] got Q=%h wv=%b exp Q=%h wv=%b", i, bus8.Q,
                 bus8.word_valid, exp_q[i], (i == 7));
      end
    end
    bus8.mode = MODE_HOLD;
    tick();
    checks++;
    if (bus8.Q !== 8'hFF || bus8.word_valid !== 1'b0) begin
      failures++;
      $display("FAIL width8_after got Q=%h wv=%b exp Q=ff wv=0", bus8.Q, bus8.word_valid);
    end
  endtask

  initial begin
    bus4.mode = MODE_HOLD;
    bus4.SDR  = 1'b0;
    bus4.SDL  = 1'b0;
    bus4.D    = '0;
    bus8.mode = MODE_HOLD;
    bus8.SDR  = 1'b0;
    bus8.SDL  = 1'b0;
    bus8.D    = '0;
    test_reset();
    test_sipo();
    test_piso();
    test_dir_change();
    test_hold();
    test_async_reset();
    test_back_to_back();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
